// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: default datapath widths and the HALT encoding.
// Combinational constants only; no latency and no backpressure.
// Imported by the IF/ID queue and its storage.
package cpu_pkg;

    localparam int DEF_PC_W    = 64;
    localparam int DEF_INSTR_W = 32;
    localparam int OPCODE_W    = 11;

    localparam logic [OPCODE_W-1:0] HALT_OPCODE = 11'h7FF;

    function automatic logic is_halt(input logic [OPCODE_W-1:0] opcode);
        return opcode == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/pipe_fifo2.sv
// Two-entry register FIFO with 1-bit wrapping pointers and an entry count.
// Latency: a write is visible at rdata on the next cycle; no same-cycle bypass.
// Backpressure: none internally; the caller qualifies push/pop against count.
module pipe_fifo2 #(
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // Reset and clear only touch control state; stale data is masked by count.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: up to two fetched {pc, instr} entries for decode, with flush and HALT stop.
// Latency: an accepted entry is presented on out_valid the following cycle.
// Backpressure: in_ready is registered-state only (not full, no HALT seen); full blocks push even on a pop.
module if_id_queue
    import cpu_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W+INSTR_W-1:0]  out_buf,
    output logic                     halt_seen,
    output logic [1:0]               occupancy
);

    logic push;
    logic pop;
    logic push_is_halt;

    assign in_ready  = (occupancy != 2'd2) && !halt_seen;
    assign out_valid = (occupancy != 2'd0);

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign push_is_halt = is_halt(in_instr[INSTR_W-1 -: OPCODE_W]);

    pipe_fifo2 #(
        .W (PC_W + INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({in_pc, in_instr}),
        .rdata (out_buf),
        .count (occupancy)
    );

    // HALT closes the intake but the HALT entry itself still drains to decode.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            halt_seen <= 1'b0;
        end else if (push && push_is_halt) begin
            halt_seen <= 1'b1;
        end
    end

    a_occ_range: assert property (@(posedge clk) disable iff (reset) occupancy != 2'd3);
    a_empty_zero: assert property (@(posedge clk) disable iff (reset) !out_valid |-> out_buf == '0);

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int EW      = PC_W + INSTR_W;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [EW-1:0]      out_buf;
    logic               halt_seen;
    logic [1:0]         occupancy;

    int tests  = 0;
    int fails  = 0;
    int delivered = 0;
    bit done   = 0;

    // Reference model: a bounded list of entries still owed to decode.
    logic [EW-1:0] mq[$];
    bit            mhalt;

    if_id_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_buf   (out_buf),
        .halt_seen (halt_seen),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT against the model mid-cycle, then advances the model.
    initial begin
        mq.delete();
        mhalt = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            begin
                logic [EW-1:0] head;
                bit m_push, m_pop, m_hlt;
                head = (mq.size() != 0) ? mq[0] : '0;
                check("occupancy", EW'(occupancy), EW'(mq.size()));
                check("out_valid", EW'(out_valid), EW'(mq.size() != 0));
                check("in_ready",  EW'(in_ready),  EW'(mq.size() < 2 && !mhalt));
                check("halt_seen", EW'(halt_seen), EW'(mhalt));
                check("out_buf",   out_buf, head);
                if (reset || flush) begin
                    mq.delete();
                    mhalt = 0;
                end else begin
                    m_pop  = (mq.size() != 0) && out_ready;
                    m_push = in_valid && (mq.size() < 2) && !mhalt;
                    m_hlt  = (in_instr[31:21] == 11'h7FF);
                    if (m_pop) begin
                        mq.pop_front();
                        delivered++;
                    end
                    if (m_push) begin
                        mq.push_back({in_pc, in_instr});
                        if (m_hlt) mhalt = 1;
                    end
                end
            end
        end
    end

    task automatic cyc(input bit rst, input bit iv, input logic [63:0] pc,
                       input logic [31:0] ins, input bit fl, input bit ordy);
        reset     = rst;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input bit ordy, input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 64'h0, 32'h0, 0, ordy);
    endtask

    initial begin
        int dcount;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Basic flow
        cyc(0, 1, 64'h0, 32'h8B020020, 0, 1);
        idle(1, 2);

        // Backpressure: third push blocked while full
        cyc(0, 1, 64'h0, 32'h00000001, 0, 0);
        cyc(0, 1, 64'h4, 32'h00000002, 0, 0);
        cyc(0, 1, 64'h8, 32'h00000003, 0, 0);
        cyc(0, 1, 64'h8, 32'h00000003, 1, 0);
        cyc(0, 1, 64'h0, 32'h00000001, 0, 0);
        cyc(0, 1, 64'h4, 32'h00000002, 0, 0);
        idle(1, 3);

        // Flush while full with a same-cycle push of PC=0x20
        cyc(0, 1, 64'h10, 32'h11, 0, 0);
        cyc(0, 1, 64'h14, 32'h12, 0, 0);
        cyc(0, 1, 64'h20, 32'h13, 1, 1);
        dcount = delivered;
        idle(1, 3);
        check("flushed_never_delivered", EW'(delivered), EW'(dcount));

        // HALT: entry delivered, later pushes ignored
        cyc(0, 1, 64'h3C, 32'hFFE00000, 0, 0);
        cyc(0, 1, 64'h40, 32'h00000040, 0, 0);
        idle(1, 2);
        cyc(0, 1, 64'h44, 32'h00000044, 0, 1);
        idle(1, 2);

        // Reset mid-operation with a full queue and HALT seen
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 64'h0, 32'h00000005, 0, 0);
        cyc(0, 1, 64'h4, 32'hFFE00001, 0, 0);
        idle(0, 1);
        cyc(1, 1, 64'h8, 32'h00000006, 1, 1);
        cyc(0, 1, 64'h0, 32'h00000007, 0, 1);
        idle(1, 2);

        // Simultaneous push and pop at occupancy 1
        cyc(0, 1, 64'h4, 32'h00000008, 0, 0);
        cyc(0, 1, 64'h8, 32'h00000009, 0, 1);
        idle(0, 2);
        idle(1, 2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 15) == 0) ins[31:21] = 11'h7FF;
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) != 0),
                {32'h0, $urandom} & 64'hFFFF_FFFC,
                ins,
                ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 2) != 0));
        end

        done = 1;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
